cpu7_excp_ctl: RTL and testbench
================================

// Module: cpu7_excp_ctl
// PURPOSE
//  Trap sequencer on the initiating side of the CSR trap interface. Qualifies _e-stage ale/illinst/ertn events and drives
//  the one-cycle ecl_csr_* strobes the CSR block consumes. Captures csr_eentry or csr_era as the fetch redirect target,
//  holds it on a valid/ready handshake to the IFU, and flushes _d/_e until the redirect has drained.
// PARAMETERS
//  DRAIN_CYCLES  1      flush cycles held after redirect acceptance (1..15)
//  ECODE_ALE     6'h09  cause code reported for address-misalign
//  ECODE_INE     6'h0d  cause code reported for illegal instruction
// PORTS
//  clk                   in   1       clock
//  resetn                in   1       asynchronous active-low reset
//  ecl_valid_e           in   1       valid instruction in _e
//  ecl_ale_e             in   1       raw misalign detect, _e
//  ecl_illinst_e         in   1       raw illegal-instruction detect, _e
//  ecl_ertn_e            in   1       ertn in _e
//  csr_eentry            in   GRLEN   exception entry from CSR
//  csr_era               in   GRLEN   return address from CSR
//  ecl_csr_ale_e         out  1       qualified ale strobe to CSR
//  ecl_csr_illinst_e     out  1       qualified illinst strobe to CSR
//  ecl_csr_ertn_e        out  1       qualified ertn strobe to CSR
//  exu_ifu_redir_vld     out  1       redirect request to IFU
//  exu_ifu_redir_pc      out  GRLEN   redirect target
//  ifu_exu_redir_rdy     in   1       IFU accepts redirect
//  ecl_flush             out  1       kill _d/_e contents
//  excp_ecode            out  6       cause of last exception taken (sticky)
// BEHAVIOUR
//  Reset state (async, immediate): IDLE; redir_vld=0, redir_pc=0, flush=0, ecode=0, all strobes 0.
//  accept = ecl_valid_e & (state==IDLE). Strobes are combinational, same cycle as pc_e, so the CSR samples pc_e:
//   ecl_csr_ale_e = accept & ecl_ale_e; ecl_csr_illinst_e = accept & ~ecl_ale_e & ecl_illinst_e;
//   ecl_csr_ertn_e = accept & ~ecl_ale_e & ~ecl_illinst_e & ecl_ertn_e. At most one strobe is high per cycle.
//  Priority: ale > illinst > ertn. Exception plus ertn in one cycle -> exception only.
//  Cycle T (any strobe high): redir_pc <= exception ? csr_eentry : csr_era (value at T; a same-cycle CSR write of EENTRY/ERA
//   is not seen). ecode <= ECODE_ALE/ECODE_INE on exception only. ertn leaves ecode unchanged. State goes to REDIR.
//  FSM:
//   IDLE  -> REDIR on any strobe.
//   REDIR -> redir_vld=1, flush=1. redir_pc stable. Hold until rdy. On vld&rdy -> DRAIN, cnt<=DRAIN_CYCLES-1.
//   DRAIN -> vld=0, flush=1. Decrement cnt. cnt==0 -> IDLE.
//  Redirect latency: strobe at T -> vld at T+1. rdy at T+1 -> flush drops at T+2+DRAIN_CYCLES.
//  flush is also asserted combinationally in cycle T, killing the _d instruction behind the trap.
//  While state!=IDLE all _e events are ignored (younger, flushed): no strobes, no ecode change.
//  rdy while vld=0 has no effect. vld never drops without rdy.
//  Reset mid-REDIR/DRAIN: immediate return to IDLE; the pending redirect is discarded.
//  cnt width is 4 bits. DRAIN_CYCLES=0 is illegal (elaboration-time check).
// STRUCTURE
//  Flops: dffrle_s for redir_pc/ecode (enable = strobe), dffrl_s for state/cnt. Target selected by dp_mux2es.
//  Shared header common.vh gains: state encodings CPU7_EXCP_IDLE/REDIR/DRAIN, ECODE_ALE/ECODE_INE defaults, GRLEN.
//  No sub-module. The FSM is inline.
// TESTING
//  1 ale with valid, eentry=0x1c000100, rdy tied 1 -> ale strobe at T, vld+pc=0x1c000100 at T+1, flush low at T+3, ecode=0x09.
//  2 illinst, rdy low 5 cycles -> vld and pc held stable for 5 cycles, accept on 6th, no second strobe.
//  3 ertn, era=0x1c000040 -> ertn strobe only, pc=0x1c000040, ecode unchanged from prior 0x0d.
//  4 ale+illinst+ertn in one cycle -> only ale strobe, ecode=0x09. ertn in REDIR/DRAIN -> no strobe.
//  5 ecl_valid_e=0 with ale=1 -> no strobe, stays IDLE. Same-cycle EENTRY write -> target uses old eentry.
//  6 resetn low during REDIR -> vld/flush 0 without clk edge. After release, a new illinst is taken normally.

Source files
------------

// File: rtl/cpu7_excp_ctl_pkg.sv
// Shared definitions for the cpu7 trap sequencer: datapath width, default
// cause codes and FSM state encodings.
package cpu7_excp_ctl_pkg;

  localparam int GRLEN = 32;

  localparam logic [5:0] ECODE_ALE_DEF = 6'h09;
  localparam logic [5:0] ECODE_INE_DEF = 6'h0d;

  typedef enum logic [1:0] {
    CPU7_EXCP_IDLE  = 2'd0,
    CPU7_EXCP_REDIR = 2'd1,
    CPU7_EXCP_DRAIN = 2'd2
  } excp_state_e;

endpackage

// File: rtl/cpu7_excp_ctl_if.sv
// Trap interface bundle: _e-stage events in, CSR strobes out, IFU redirect
// handshake, flush and sticky cause code.
interface cpu7_excp_ctl_if;
  import cpu7_excp_ctl_pkg::*;

  logic             ecl_valid_e;
  logic             ecl_ale_e;
  logic             ecl_illinst_e;
  logic             ecl_ertn_e;
  logic [GRLEN-1:0] csr_eentry;
  logic [GRLEN-1:0] csr_era;
  logic             ecl_csr_ale_e;
  logic             ecl_csr_illinst_e;
  logic             ecl_csr_ertn_e;
  logic             exu_ifu_redir_vld;
  logic [GRLEN-1:0] exu_ifu_redir_pc;
  logic             ifu_exu_redir_rdy;
  logic             ecl_flush;
  logic [5:0]       excp_ecode;

  modport master (
    input  ecl_valid_e, ecl_ale_e, ecl_illinst_e, ecl_ertn_e,
    input  csr_eentry, csr_era, ifu_exu_redir_rdy,
    output ecl_csr_ale_e, ecl_csr_illinst_e, ecl_csr_ertn_e,
    output exu_ifu_redir_vld, exu_ifu_redir_pc, ecl_flush, excp_ecode
  );

  modport slave (
    output ecl_valid_e, ecl_ale_e, ecl_illinst_e, ecl_ertn_e,
    output csr_eentry, csr_era, ifu_exu_redir_rdy,
    input  ecl_csr_ale_e, ecl_csr_illinst_e, ecl_csr_ertn_e,
    input  exu_ifu_redir_vld, exu_ifu_redir_pc, ecl_flush, excp_ecode
  );

endinterface

// File: rtl/cpu7_excp_ctl.sv
// Trap sequencer: qualifies _e-stage ale/illinst/ertn, strobes the CSR block,
// then holds a fetch redirect to the IFU and flushes _d/_e until it drains.
module cpu7_excp_ctl
  import cpu7_excp_ctl_pkg::*;
#(
  parameter int         DRAIN_CYCLES = 1,
  parameter logic [5:0] ECODE_ALE    = ECODE_ALE_DEF,
  parameter logic [5:0] ECODE_INE    = ECODE_INE_DEF
) (
  input  logic             clk,
  input  logic             resetn,
  cpu7_excp_ctl_if.master  bus
);

  if (DRAIN_CYCLES < 1 || DRAIN_CYCLES > 15) begin : g_bad_drain
    $error("cpu7_excp_ctl: DRAIN_CYCLES must be within 1..15");
  end

  localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES - 1);

  excp_state_e      state, state_nxt;
  logic [3:0]       cnt, cnt_nxt;
  logic [GRLEN-1:0] redir_pc;
  logic [5:0]       ecode;
  logic             accept;
  logic             ale_stb, ill_stb, ertn_stb;
  logic             take_excp, any_stb;

  // Strobes are combinational so the CSR block samples them alongside pc_e.
  assign accept    = bus.ecl_valid_e & (state == CPU7_EXCP_IDLE);
  assign ale_stb   = accept & bus.ecl_ale_e;
  assign ill_stb   = accept & ~bus.ecl_ale_e & bus.ecl_illinst_e;
  assign ertn_stb  = accept & ~bus.ecl_ale_e & ~bus.ecl_illinst_e & bus.ecl_ertn_e;
  assign take_excp = ale_stb | ill_stb;
  assign any_stb   = take_excp | ertn_stb;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= CPU7_EXCP_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Target and cause are captured from the CSR values visible in the strobe cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      redir_pc <= '0;
      ecode    <= '0;
    end else if (any_stb) begin
      redir_pc <= take_excp ? bus.csr_eentry : bus.csr_era;
      if (take_excp) begin
        ecode <= ale_stb ? ECODE_ALE : ECODE_INE;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      CPU7_EXCP_IDLE: begin
        if (any_stb) state_nxt = CPU7_EXCP_REDIR;
      end
      CPU7_EXCP_REDIR: begin
        if (bus.ifu_exu_redir_rdy) begin
          state_nxt = CPU7_EXCP_DRAIN;
          cnt_nxt   = DRAIN_INIT;
        end
      end
      CPU7_EXCP_DRAIN: begin
        if (cnt == 4'd0) state_nxt = CPU7_EXCP_IDLE;
        else             cnt_nxt   = cnt - 4'd1;
      end
      default: state_nxt = CPU7_EXCP_IDLE;
    endcase
  end

  assign bus.ecl_csr_ale_e     = ale_stb;
  assign bus.ecl_csr_illinst_e = ill_stb;
  assign bus.ecl_csr_ertn_e    = ertn_stb;
  assign bus.exu_ifu_redir_vld = (state == CPU7_EXCP_REDIR);
  assign bus.exu_ifu_redir_pc  = redir_pc;
  assign bus.ecl_flush         = (state != CPU7_EXCP_IDLE) | any_stb;
  assign bus.excp_ecode        = ecode;

endmodule

// File: tb/tb_cpu7_excp_ctl.sv
// Directed bench for cpu7_excp_ctl: each step drives events 1ns after the
// rising edge and checks outputs mid-cycle against hand-computed values.
module tb_cpu7_excp_ctl;
  import cpu7_excp_ctl_pkg::*;

  logic clk;
  logic resetn;
  int   total_checks;
  int   passed_checks;

  cpu7_excp_ctl_if bus();

  cpu7_excp_ctl #(
    .DRAIN_CYCLES(1),
    .ECODE_ALE   (6'h09),
    .ECODE_INE   (6'h0d)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic valid, input logic ale, input logic ill,
                               input logic ertn, input logic rdy);
    bus.ecl_valid_e       = valid;
    bus.ecl_ale_e         = ale;
    bus.ecl_illinst_e     = ill;
    bus.ecl_ertn_e        = ertn;
    bus.ifu_exu_redir_rdy = rdy;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total_checks++;
    assert (observed === expected) passed_checks++;
    else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
  endtask

  task automatic checkStrobes(input string tag, input logic ale, input logic ill,
                              input logic ertn);
    checkOutput({tag, "_ale"},  32'(bus.ecl_csr_ale_e),     32'(ale));
    checkOutput({tag, "_ill"},  32'(bus.ecl_csr_illinst_e), 32'(ill));
    checkOutput({tag, "_ertn"}, 32'(bus.ecl_csr_ertn_e),    32'(ertn));
  endtask

  task automatic checkRedir(input string tag, input logic vld, input logic flush);
    checkOutput({tag, "_vld"},   32'(bus.exu_ifu_redir_vld), 32'(vld));
    checkOutput({tag, "_flush"}, 32'(bus.ecl_flush),         32'(flush));
  endtask

  // Advance to 1ns past the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    total_checks  = 0;
    passed_checks = 0;
    resetn        = 1'b0;
    bus.csr_eentry = 32'h0;
    bus.csr_era    = 32'h0;
    applyStimulus(0, 0, 0, 0, 0);
    #3;
    checkStrobes("reset", 0, 0, 0);
    checkRedir("reset", 0, 0);
    checkOutput("reset_pc",    bus.exu_ifu_redir_pc, 32'h0);
    checkOutput("reset_ecode", 32'(bus.excp_ecode),  32'h0);
    step();
    resetn = 1'b1;

    // 1: ale with rdy tied high
    step();
    bus.csr_eentry = 32'h1c000100;
    applyStimulus(1, 1, 0, 0, 1);
    #3;
    checkStrobes("t1_T", 1, 0, 0);
    checkRedir("t1_T", 0, 1);
    step();
    applyStimulus(0, 0, 0, 0, 1);
    #3;
    checkRedir("t1_T1", 1, 1);
    checkOutput("t1_pc",    bus.exu_ifu_redir_pc, 32'h1c000100);
    checkOutput("t1_ecode", 32'(bus.excp_ecode),  32'h09);
    step();
    #3;
    checkRedir("t1_T2", 0, 1);
    step();
    #3;
    checkRedir("t1_T3", 0, 0);

    // 2: illinst with rdy withheld for 5 cycles
    step();
    bus.csr_eentry = 32'h1c000200;
    applyStimulus(1, 0, 1, 0, 0);
    #3;
    checkStrobes("t2_T", 0, 1, 0);
    for (int i = 0; i < 5; i++) begin
      step();
      bus.csr_eentry = 32'hdead0000 + 32'(i);
      applyStimulus(1, 0, 1, 0, 0);
      #3;
      checkStrobes("t2_hold", 0, 0, 0);
      checkRedir("t2_hold", 1, 1);
      checkOutput("t2_hold_pc", bus.exu_ifu_redir_pc, 32'h1c000200);
    end
    step();
    applyStimulus(1, 0, 1, 0, 1);
    #3;
    checkRedir("t2_acc", 1, 1);
    checkOutput("t2_acc_pc", bus.exu_ifu_redir_pc, 32'h1c000200);
    checkStrobes("t2_acc", 0, 0, 0);
    step();
    applyStimulus(0, 0, 0, 0, 0);
    #3;
    checkRedir("t2_drain", 0, 1);
    checkOutput("t2_ecode", 32'(bus.excp_ecode), 32'h0d);
    step();
    #3;
    checkRedir("t2_idle", 0, 0);

    // 3: ertn targets era and leaves ecode alone
    step();
    bus.csr_era = 32'h1c000040;
    applyStimulus(1, 0, 0, 1, 1);
    #3;
    checkStrobes("t3_T", 0, 0, 1);
    step();
    #3;
    checkRedir("t3_T1", 1, 1);
    checkOutput("t3_pc",    bus.exu_ifu_redir_pc, 32'h1c000040);
    checkOutput("t3_ecode", 32'(bus.excp_ecode),  32'h0d);
    step();
    applyStimulus(1, 0, 0, 1, 1);
    #3;
    checkStrobes("t3_drain", 0, 0, 0);
    checkRedir("t3_drain", 0, 1);
    step();
    applyStimulus(0, 0, 0, 0, 0);
    #3;
    checkRedir("t3_idle", 0, 0);

    // 4: all three events at once; ale wins, later ertn ignored
    step();
    bus.csr_eentry = 32'h1c000300;
    applyStimulus(1, 1, 1, 1, 0);
    #3;
    checkStrobes("t4_T", 1, 0, 0);
    step();
    applyStimulus(1, 0, 0, 1, 0);
    #3;
    checkStrobes("t4_redir", 0, 0, 0);
    checkRedir("t4_redir", 1, 1);
    checkOutput("t4_pc",    bus.exu_ifu_redir_pc, 32'h1c000300);
    checkOutput("t4_ecode", 32'(bus.excp_ecode),  32'h09);
    step();
    applyStimulus(0, 0, 0, 0, 1);
    #3;
    checkRedir("t4_acc", 1, 1);
    step();
    applyStimulus(1, 0, 0, 1, 0);
    #3;
    checkStrobes("t4_drain", 0, 0, 0);
    checkRedir("t4_drain", 0, 1);
    step();
    applyStimulus(0, 0, 0, 0, 0);
    #3;
    checkRedir("t4_idle", 0, 0);

    // 5: unqualified ale ignored; same-cycle EENTRY write not seen
    step();
    applyStimulus(0, 1, 0, 0, 0);
    #3;
    checkStrobes("t5_noval", 0, 0, 0);
    checkRedir("t5_noval", 0, 0);
    step();
    bus.csr_eentry = 32'h1c000400;
    applyStimulus(1, 1, 0, 0, 0);
    #3;
    checkRedir("t5_noval_next", 0, 1);
    checkStrobes("t5_T", 1, 0, 0);
    step();
    bus.csr_eentry = 32'h1c000500;
    applyStimulus(0, 0, 0, 0, 1);
    #3;
    checkRedir("t5_T1", 1, 1);
    checkOutput("t5_pc", bus.exu_ifu_redir_pc, 32'h1c000400);
    step();
    applyStimulus(0, 0, 0, 0, 0);
    step();
    #3;
    checkRedir("t5_idle", 0, 0);

    // 6: reset in REDIR discards the redirect; a fresh trap is taken after
    step();
    bus.csr_eentry = 32'h1c000600;
    applyStimulus(1, 0, 1, 0, 0);
    #3;
    checkStrobes("t6_T", 0, 1, 0);
    step();
    applyStimulus(0, 0, 0, 0, 0);
    #3;
    checkRedir("t6_redir", 1, 1);
    #1;
    resetn = 1'b0;
    #1;
    checkRedir("t6_rst", 0, 0);
    checkOutput("t6_rst_pc",    bus.exu_ifu_redir_pc, 32'h0);
    checkOutput("t6_rst_ecode", 32'(bus.excp_ecode),  32'h0);
    step();
    resetn = 1'b1;
    step();
    bus.csr_eentry = 32'h1c000700;
    applyStimulus(1, 0, 1, 0, 1);
    #3;
    checkStrobes("t6_new", 0, 1, 0);
    step();
    applyStimulus(0, 0, 0, 0, 1);
    #3;
    checkRedir("t6_new_T1", 1, 1);
    checkOutput("t6_new_pc",    bus.exu_ifu_redir_pc, 32'h1c000700);
    checkOutput("t6_new_ecode", 32'(bus.excp_ecode),  32'h0d);
    step();
    applyStimulus(0, 0, 0, 0, 0);
    #3;
    checkRedir("t6_new_drain", 0, 1);
    step();
    #3;
    checkRedir("t6_new_idle", 0, 0);

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
